// File: rtl/scope_trace_render.sv
// Scope display pixel stage: captures a triggered 640-sample record into a ping-pong buffer
// and renders it as a trace with graticule and trigger marker, two cycles behind the timing inputs.
module scope_trace_render #(
  parameter int unsigned TRACE_TOP    = 112,
  parameter int unsigned AUTO_TIMEOUT = 1048575
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  input  logic [7:0] trig_level,
  input  logic       Hsync,
  input  logic       Vsync,
  input  logic       Blank,
  input  logic [9:0] Pixel_x,
  input  logic [9:0] Pixel_y,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       R,
  output logic       G,
  output logic       B,
  output logic       capture_busy
);

  typedef enum logic [1:0] {StArm, StCapture, StDone} state_e;

  state_e      state_q, state_d;
  logic [9:0]  waddr_q, waddr_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        front_q, front_d;
  logic        have_trace_q, have_trace_d;
  logic [7:0]  prev_q, prev_d;
  logic        we;
  logic [9:0]  wa;
  logic        crossing, timeout;

  logic [7:0]  mem0 [0:639];
  logic [7:0]  mem1 [0:639];
  logic [9:0]  rd_addr;
  logic [7:0]  rd_q;

  logic [9:0]  x1_q, y1_q;
  logic        vis1_q, blank1_q, hs1_q, vs1_q;
  logic [7:0]  lvl1_q;
  logic [9:0]  trace_row, marker_row;
  logic        r_c, g_c, b_c;

  assign crossing = sample_valid && (prev_q < trig_level) && (sample >= trig_level);
  assign timeout  = (tcnt_q == AUTO_TIMEOUT);

  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    front_d      = front_q;
    have_trace_d = have_trace_q;
    prev_d       = prev_q;
    we           = 1'b0;
    wa           = waddr_q;
    tcnt_d       = (state_q == StArm) ? tcnt_q + 32'd1 : '0;
    unique case (state_q)
      StArm: begin
        if (sample_valid) prev_d = sample;
        if (crossing || timeout) begin
          state_d = StCapture;
          // A timeout without a valid sample leaves address 0 for the next one.
          if (sample_valid) begin
            we      = 1'b1;
            wa      = '0;
            waddr_d = 10'd1;
          end else begin
            waddr_d = '0;
          end
        end
      end
      StCapture: begin
        if (sample_valid) begin
          we = 1'b1;
          if (waddr_q == 10'd639) begin
            state_d = StDone;
            waddr_d = '0;
          end else begin
            waddr_d = waddr_q + 10'd1;
          end
        end
      end
      StDone: begin
        if (Pixel_x == 10'd0 && Pixel_y == 10'd480) begin
          front_d      = ~front_q;
          have_trace_d = 1'b1;
          state_d      = StArm;
        end
      end
      default: state_d = StArm;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StArm;
      waddr_q      <= '0;
      tcnt_q       <= '0;
      front_q      <= 1'b0;
      have_trace_q <= 1'b0;
      prev_q       <= '0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      tcnt_q       <= tcnt_d;
      front_q      <= front_d;
      have_trace_q <= have_trace_d;
      prev_q       <= prev_d;
    end
  end

  assign capture_busy = (state_q != StArm);
  assign rd_addr      = (Pixel_x < 10'd640) ? Pixel_x : '0;

  // Writes go to the back bank, reads to the front bank: never the same array.
  always_ff @(posedge clk) begin
    if (we && !front_q) mem1[wa] <= sample;
    if (we && front_q)  mem0[wa] <= sample;
    rd_q <= front_q ? mem1[rd_addr] : mem0[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1_q     <= '0;
      y1_q     <= '0;
      vis1_q   <= 1'b0;
      blank1_q <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      lvl1_q   <= '0;
    end else begin
      x1_q     <= Pixel_x;
      y1_q     <= Pixel_y;
      vis1_q   <= (Pixel_x < 10'd640);
      blank1_q <= Blank;
      hs1_q    <= Hsync;
      vs1_q    <= Vsync;
      lvl1_q   <= trig_level;
    end
  end

  always_comb begin
    trace_row  = 10'(TRACE_TOP) + (10'd255 - {2'b00, rd_q});
    marker_row = 10'(TRACE_TOP) + (10'd255 - {2'b00, lvl1_q});
    g_c        = have_trace_q && vis1_q && (y1_q == trace_row);
    b_c        = (x1_q[5:0] == 6'd0) || (y1_q[4:0] == 5'd0);
    r_c        = (x1_q < 10'd8) && (y1_q == marker_row);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      R     <= 1'b0;
      G     <= 1'b0;
      B     <= 1'b0;
      HSYNC <= 1'b1;
      VSYNC <= 1'b1;
    end else begin
      R     <= blank1_q & r_c;
      G     <= blank1_q & g_c;
      B     <= blank1_q & b_c;
      HSYNC <= hs1_q;
      VSYNC <= vs1_q;
    end
  end

endmodule

// File: tb/tb_scope_trace_render.sv
// Directed bench for scope_trace_render with hand-computed trace rows and capture timing.
module tb_scope_trace_render;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample = '0;
  logic [7:0] trig_level = 8'd128;
  logic       Hsync = 1'b1, Vsync = 1'b1, Blank = 1'b1;
  logic [9:0] Pixel_x = 10'd100, Pixel_y = 10'd100;
  logic       HSYNC, VSYNC, R, G, B, capture_busy;

  int errors = 0;
  int checks = 0;

  scope_trace_render #(.TRACE_TOP(112), .AUTO_TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .trig_level(trig_level), .Hsync(Hsync), .Vsync(Vsync), .Blank(Blank),
    .Pixel_x(Pixel_x), .Pixel_y(Pixel_y), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .R(R), .G(G), .B(B), .capture_busy(capture_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic show(input int x, input int y, input logic bl);
    Pixel_x = 10'(x);
    Pixel_y = 10'(y);
    Blank   = bl;
    tick();
    tick();
  endtask

  task automatic feed(input int v, input int n);
    sample       = 8'(v);
    sample_valid = 1'b1;
    repeat (n) tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_swap();
    Pixel_x = 10'd0;
    Pixel_y = 10'd480;
    tick();
    Pixel_x = 10'd100;
    Pixel_y = 10'd100;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check_eq("rst_rgb", {R, G, B}, 3'b000);
    check_eq("rst_sync", {HSYNC, VSYNC}, 2'b11);
    check_eq("rst_busy", capture_busy, 0);
    repeat (2) tick();
    rst = 1'b0;

    // Static rendering before any record exists
    show(64, 32, 1'b1);
    check_eq("grat_b", B, 1);
    check_eq("grat_g", G, 0);
    show(3, 239, 1'b1);
    check_eq("marker_r", {R, B}, 2'b10);
    show(8, 239, 1'b1);
    check_eq("marker_r_x8", R, 0);
    show(0, 239, 1'b0);
    check_eq("blank_rgb", {R, G, B}, 3'b000);
    Blank = 1'b1;
    Hsync = 1'b0;
    tick();
    check_eq("hsync_lat1", HSYNC, 1);
    tick();
    check_eq("hsync_lat2", HSYNC, 0);
    Hsync = 1'b1;
    Pixel_x = 10'd100;
    Pixel_y = 10'd100;

    // Ramp capture triggered on the 127->128 crossing
    tick();
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int v = 100; v < 128; v++) feed(v, 1);
    check_eq("ramp_busy_pre", capture_busy, 0);
    feed(128, 1);
    check_eq("ramp_busy_rise", capture_busy, 1);
    for (int i = 1; i < 640; i++) feed((128 + i) % 256, 1);
    feed(5, 3);
    check_eq("ramp_busy_done", capture_busy, 1);
    show(0, 239, 1'b1);
    check_eq("ramp_no_trace_yet", G, 0);
    do_swap();
    check_eq("ramp_swap_busy", capture_busy, 0);
    show(0, 239, 1'b1);
    check_eq("ramp_x0", G, 1);
    show(639, 112, 1'b1);
    check_eq("ramp_x639", G, 1);
    show(127, 112, 1'b1);
    check_eq("ramp_x127", G, 1);
    show(128, 367, 1'b1);
    check_eq("ramp_x128", G, 1);
    show(128, 366, 1'b1);
    check_eq("ramp_x128_off", G, 0);

    // Constant 64 captured by timeout -> row 303
    feed(64, 800);
    check_eq("c64_busy", capture_busy, 1);
    do_swap();
    show(320, 302, 1'b1);
    check_eq("c64_row302", G, 0);
    Pixel_y = 10'd303;
    tick();
    check_eq("c64_lat1", G, 0);
    tick();
    check_eq("c64_lat2", G, 1);
    show(0, 303, 1'b1);
    check_eq("c64_x0", G, 1);
    show(639, 303, 1'b1);
    check_eq("c64_x639", G, 1);
    show(640, 303, 1'b1);
    check_eq("c64_x640", G, 0);
    show(320, 304, 1'b1);
    check_eq("c64_row304", G, 0);

    // Reset at capture address 300
    feed(0, 1);
    feed(200, 1);
    check_eq("mid_busy", capture_busy, 1);
    feed(200, 299);
    Hsync = 1'b0;
    show(64, 32, 1'b1);
    check_eq("mid_pre_b", B, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_rgb", {R, G, B}, 3'b000);
    check_eq("mid_rst_hsync", HSYNC, 1);
    check_eq("mid_rst_busy", capture_busy, 0);
    Hsync = 1'b1;
    Pixel_x = 10'd0;
    Pixel_y = 10'd303;
    trig_level = 8'd200;
    rst = 1'b0;

    // No crossing: forced capture at ARM cycle 100
    sample = 8'd10;
    sample_valid = 1'b1;
    repeat (100) tick();
    check_eq("to_busy_pre", capture_busy, 0);
    check_eq("to_masked", G, 0);
    tick();
    check_eq("to_busy_rise", capture_busy, 1);
    repeat (639) tick();
    sample_valid = 1'b0;
    tick();
    check_eq("to_busy_done", capture_busy, 1);
    do_swap();
    show(5, 357, 1'b1);
    check_eq("to_row357", G, 1);
    show(5, 356, 1'b1);
    check_eq("to_row356", G, 0);

    // New record captured mid-frame shows only after line 480
    feed(0, 1);
    feed(255, 640);
    show(5, 357, 1'b1);
    check_eq("mf_old_kept", G, 1);
    show(5, 112, 1'b1);
    check_eq("mf_new_hidden", G, 0);
    show(0, 479, 1'b1);
    check_eq("mf_busy_479", capture_busy, 1);
    show(0, 480, 1'b1);
    check_eq("mf_busy_480", capture_busy, 0);
    show(5, 112, 1'b1);
    check_eq("mf_new_shown", G, 1);
    show(5, 357, 1'b1);
    check_eq("mf_old_gone", G, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
